mul_exec_unit: RTL

//  Multi-cycle shift-add multiplier in the execute stage, directly downstream of the
//  src1/src2 operand muxes. Consumes the selected operands (src1 = Rs path for MUL)
//  and produces a 2*WIDTH product for writeback.

---
 rtl/mul_exec_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_exec_unit.sv
// mul_exec_unit
//   Multi-cycle shift-add multiplier for the execute stage. Takes the operands
//   selected by the src1/src2 muxes and produces a 2*WIDTH product for
//   writeback. The control unit stalls issue while busy is high.
//
//   Build option: define MUL_SIGNED_EN to add the signed_op port and
//   two's-complement multiply support. Without it every multiply is unsigned.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request; operands sampled when accepted (IDLE or DONE)
//   src1       multiplicand
//   src2       multiplier
//   signed_op  1 = two's-complement multiply (MUL_SIGNED_EN builds only)
//   busy       high while a multiply is running
//   done       one-cycle pulse; result valid from this cycle on
//   result     2*WIDTH product, held until the next completed multiply
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one shift-add step per cycle, WIDTH steps, fixed latency
// DONE  | done pulse; a new start is accepted here as in IDLE
module mul_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
`ifdef MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
`ifdef MUL_SIGNED_EN
    logic               neg_q,    neg_d;
`endif

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] acc_step;

    // Operand magnitudes. The most-negative value negates to itself, which
    // read as unsigned is exactly its magnitude, so no special case is needed.
    always_comb begin
        mag1 = src1;
        mag2 = src2;
`ifdef MUL_SIGNED_EN
        if (signed_op) begin
            if (src1[WIDTH-1]) mag1 = -src1;
            if (src2[WIDTH-1]) mag2 = -src2;
        end
`endif
    end

    // mcand_q is shifted left one place per step, which equals mcand << counter.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef MUL_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MUL_SIGNED_EN
                    neg_d    = signed_op & (src1[WIDTH-1] ^ src2[WIDTH-1]);
`endif
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
                    // Sign fix-up folded into the final write keeps latency fixed.
                    result_d = neg_q ? -acc_step : acc_step;
`else
                    result_d = acc_step;
`endif
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MUL_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef MUL_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
